// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: data width default,
// RV64 load/store func3 codes, FSM state encoding and the byte-size mask helper.
package lsu_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Byte-lane mask of an access of 2**sz bytes starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality, store lane shift/mask and
// load byte extraction with sign/zero extension.
module lsu_align import lsu_pkg::*; #(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            wen,
    input  logic [2:0]      func3,
    input  logic [2:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic            err,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext
);

    logic            illegal_s;
    logic            misalign_s;
    logic [XLEN-1:0] rdata_sh_s;

    // Illegal encoding or natural-alignment violation for the access size.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (wen) begin
            illegal_s = func3[2];
        end else begin
            illegal_s = (func3 == F3_ILL);
        end
        case (func3[1:0])
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = addr_lo[0];
            2'b10:   misalign_s = |addr_lo[1:0];
            2'b11:   misalign_s = |addr_lo;
            default: misalign_s = 1'b0;
        endcase
        err = illegal_s | misalign_s;
    end

    // Store data and byte enables moved onto the addressed lanes.
    always_comb begin
        wmask    = size_mask(func3[1:0]) << addr_lo;
        wdata_sh = wdata << {addr_lo, 3'b000};
    end

    // Load data brought down to lane 0, then truncated and extended.
    always_comb begin
        rdata_sh_s = rdata >> {addr_lo, 3'b000};
        case (func3)
            F3_B:    rdata_ext = {{(XLEN-8){rdata_sh_s[7]}}, rdata_sh_s[7:0]};
            F3_H:    rdata_ext = {{(XLEN-16){rdata_sh_s[15]}}, rdata_sh_s[15:0]};
            F3_W:    rdata_ext = {{(XLEN-32){rdata_sh_s[31]}}, rdata_sh_s[31:0]};
            F3_D:    rdata_ext = rdata_sh_s;
            F3_BU:   rdata_ext = {{(XLEN-8){1'b0}}, rdata_sh_s[7:0]};
            F3_HU:   rdata_ext = {{(XLEN-16){1'b0}}, rdata_sh_s[15:0]};
            F3_WU:   rdata_ext = {{(XLEN-32){1'b0}}, rdata_sh_s[31:0]};
            default: rdata_ext = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, drives an aligned
// doubleword memory port and returns an extended load result or an error.
module lsu import lsu_pkg::*; #(
    parameter int XLEN        = XLEN_DEF,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [2:0]      req_func3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_raddr,
    output logic [XLEN-1:0] mem_waddr,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    output logic            mem_wen
);

    state_t          state_r;
    logic            wen_r;
    logic [2:0]      func3_r;
    logic [2:0]      addr_lo_r;
    logic [3:0]      cnt_r;
    logic            req_ready_r;
    logic            resp_valid_r;
    logic [XLEN-1:0] resp_rdata_r;
    logic            resp_err_r;
    logic [XLEN-1:0] mem_addr_r;
    logic [XLEN-1:0] mem_wdata_r;
    logic [7:0]      mem_wmask_r;
    logic            mem_wen_r;

    logic            al_wen_s;
    logic [2:0]      al_func3_s;
    logic [2:0]      al_addr_lo_s;
    logic            al_err_s;
    logic [7:0]      al_wmask_s;
    logic [XLEN-1:0] al_wdata_s;
    logic [XLEN-1:0] al_rdata_s;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched op.
    always_comb begin
        al_wen_s     = wen_r;
        al_func3_s   = func3_r;
        al_addr_lo_s = addr_lo_r;
        if (state_r == ST_IDLE) begin
            al_wen_s     = req_wen;
            al_func3_s   = req_func3;
            al_addr_lo_s = req_addr[2:0];
        end else begin
            al_wen_s     = wen_r;
            al_func3_s   = func3_r;
            al_addr_lo_s = addr_lo_r;
        end
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .wen       (al_wen_s),
        .func3     (al_func3_s),
        .addr_lo   (al_addr_lo_s),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .err       (al_err_s),
        .wmask     (al_wmask_s),
        .wdata_sh  (al_wdata_s),
        .rdata_ext (al_rdata_s)
    );

    // Request/access/response sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wen_r        <= 1'b0;
            func3_r      <= 3'b000;
            addr_lo_r    <= 3'b000;
            cnt_r        <= 4'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_err_r   <= 1'b0;
            mem_addr_r   <= {XLEN{1'b0}};
            mem_wdata_r  <= {XLEN{1'b0}};
            mem_wmask_r  <= 8'h00;
            mem_wen_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        wen_r       <= req_wen;
                        func3_r     <= req_func3;
                        addr_lo_r   <= req_addr[2:0];
                        req_ready_r <= 1'b0;
                        if (al_err_s) begin
                            // Faulting ops never touch memory.
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= {XLEN{1'b0}};
                        end else begin
                            state_r     <= ST_ACCESS;
                            cnt_r       <= 4'(MEM_LATENCY - 1);
                            mem_addr_r  <= {req_addr[XLEN-1:3], 3'b000};
                            mem_wen_r   <= req_wen;
                            mem_wmask_r <= req_wen ? al_wmask_s : 8'h00;
                            mem_wdata_r <= req_wen ? al_wdata_s : {XLEN{1'b0}};
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_wen_r <= 1'b0;
                    if (cnt_r == 4'd0) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= wen_r ? {XLEN{1'b0}} : al_rdata_s;
                        mem_addr_r   <= {XLEN{1'b0}};
                        mem_wmask_r  <= 8'h00;
                        mem_wdata_r  <= {XLEN{1'b0}};
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r      <= ST_IDLE;
                        req_ready_r  <= 1'b1;
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= {XLEN{1'b0}};
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {XLEN{1'b0}};
                    mem_addr_r   <= {XLEN{1'b0}};
                    mem_wmask_r  <= 8'h00;
                    mem_wdata_r  <= {XLEN{1'b0}};
                    mem_wen_r    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_raddr  = mem_addr_r;
    assign mem_waddr  = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wmask  = mem_wmask_r;
    assign mem_wen    = mem_wen_r;

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized bench for lsu, checked against a byte-level
// reference model of RV64 load/store semantics.
module tb_lsu;

    localparam int XLEN = 64;
    localparam int LAT  = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [2:0]      req_func3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic [XLEN-1:0] mem_raddr;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_wen;

    int vectors = 0;
    int fails   = 0;

    lsu #(.XLEN(XLEN), .MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_wen    (mem_wen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- reference model: access size in bytes, legality, lanes, extension ----
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_err(input logic wen, input logic [2:0] f3, input logic [63:0] a);
        logic illegal;
        illegal = wen ? (f3 >= 3'd4) : (f3 == 3'd7);
        return illegal || ((a % 64'(nbytes(f3))) != 64'd0);
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input int lo, input logic [63:0] d);
        logic [63:0] v;
        int nb;
        nb = nbytes(f3);
        v  = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(lo+i) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] f3, input int lo);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < nbytes(f3); i++) if (lo + i < 8) m[lo+i] = 1'b1;
        return m;
    endfunction

    // One complete op: issue, check memory side, wait for response, hold, handshake.
    task automatic do_op(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input int hold,
                         output logic [63:0] got_rdata, output logic [63:0] got_waddr,
                         output logic [63:0] got_wdata, output logic [7:0] got_wmask);
        logic        e_err;
        logic [63:0] e_rdata;
        logic        got_err;
        int          n;
        int          lo;
        lo      = int'(addr[2:0]);
        e_err   = m_err(wen, f3, addr);
        e_rdata = (e_err || wen) ? 64'd0 : m_load(f3, lo, rdata);

        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = wen; req_func3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = rdata;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);

        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        got_waddr  = mem_waddr;
        got_wdata  = mem_wdata;
        got_wmask  = mem_wmask;
        chk("req_ready_busy", {63'd0, req_ready}, 64'd0);
        if (e_err) begin
            chk("err_resp_at_t1", {63'd0, resp_valid}, 64'd1);
            chk("err_no_mem_wen", {63'd0, mem_wen}, 64'd0);
            chk("err_no_mem_addr", mem_raddr, 64'd0);
        end else begin
            chk("access_no_resp", {63'd0, resp_valid}, 64'd0);
            chk("mem_raddr", mem_raddr, {addr[63:3], 3'b000});
            chk("mem_waddr", mem_waddr, {addr[63:3], 3'b000});
            chk("mem_wen_first", {63'd0, mem_wen}, {63'd0, wen});
            if (wen) begin
                chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, m_mask(f3, lo)});
                chk("mem_wdata", mem_wdata, wdata << (8 * lo));
            end
            n = 1;
            while (!resp_valid && n < 40) begin
                @(posedge clk); #1;
                n++;
                if (!resp_valid) chk("mem_wen_once", {63'd0, mem_wen}, 64'd0);
            end
            chk("resp_latency", 64'(n), 64'(1 + LAT));
            chk("resp_mem_idle", {55'd0, mem_wen, mem_wmask}, 64'd0);
            chk("resp_mem_addr", mem_waddr, 64'd0);
        end
        chk("resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("resp_err", {63'd0, resp_err}, {63'd0, e_err});
        chk("resp_rdata", resp_rdata, e_rdata);
        got_rdata = resp_rdata;
        got_err   = resp_err;

        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_wen = 1'($urandom); req_func3 = 3'($urandom);
            req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold_rdata", resp_rdata, got_rdata);
            chk("hold_err", {63'd0, resp_err}, {63'd0, got_err});
            chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
            chk("hold_mem_wen", {63'd0, mem_wen}, 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("handshake_done", {63'd0, resp_valid}, 64'd0);
        chk("back_to_idle", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] r, wa, wd, a, d;
        logic [7:0]  wm;
        logic [2:0]  f3;
        logic        w;

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_func3 = 3'b000;
        req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0; mem_rdata = 64'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_mem", {55'd0, mem_wen, mem_wmask}, 64'd0);
        chk("rst_mem_addr", mem_raddr | mem_waddr | mem_wdata, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

        // LB of a negative byte
        do_op(1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'd0, 64'h0000_0000_80FF_0000, 0, r, wa, wd, wm);
        chk("lb_value", r, 64'hFFFF_FFFF_FFFF_FF80);

        // SH into the top halfword
        do_op(1'b1, 3'b001, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 64'd0, 0, r, wa, wd, wm);
        chk("sh_waddr", wa, 64'h0000_0000_8000_0000);
        chk("sh_wmask", {56'd0, wm}, 64'h0000_0000_0000_00C0);
        chk("sh_wdata", wd, 64'h1234_0000_0000_0000);

        // Misaligned LW
        do_op(1'b0, 3'b010, 64'h0000_0000_8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, r, wa, wd, wm);
        chk("lw_mis_rdata", r, 64'd0);

        // LWU with back-pressure
        do_op(1'b0, 3'b110, 64'h0000_0000_8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 3, r, wa, wd, wm);
        chk("lwu_value", r, 64'h0000_0000_DEAD_BEEF);

        // Illegal store and illegal load encodings
        do_op(1'b1, 3'b100, 64'h0000_0000_8000_0000, 64'h55, 64'd0, 1, r, wa, wd, wm);
        do_op(1'b0, 3'b111, 64'h0000_0000_8000_0000, 64'd0, 64'h1, 0, r, wa, wd, wm);

        // Reset during the ACCESS cycle of an SD aborts it
        @(posedge clk); #1;
        req_valid = 1'b1; req_wen = 1'b1; req_func3 = 3'b011;
        req_addr = 64'h0000_0000_8000_0008; req_wdata = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sd_in_access", {63'd0, mem_wen}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_mem_wen", {63'd0, mem_wen}, 64'd0);
        chk("abort_mem_waddr", mem_waddr, 64'd0);
        chk("abort_resp", {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("post_abort_quiet", {62'd0, resp_valid, mem_wen}, 64'd0);
            chk("post_abort_ready", {63'd0, req_ready}, 64'd1);
        end
        do_op(1'b0, 3'b011, 64'h0000_0000_8000_0008, 64'd0, 64'hCAFE_F00D_1234_5678, 0, r, wa, wd, wm);
        chk("ld_after_abort", r, 64'hCAFE_F00D_1234_5678);

        // Randomized ops
        for (int k = 0; k < 300; k++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~(64'(nbytes(f3)) - 64'd1);
            d  = {$urandom, $urandom};
            do_op(w, f3, a, {$urandom, $urandom}, d, ($urandom_range(0, 3) == 0) ? 2 : 0, r, wa, wd, wm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
